// File: rtl/tlp_req_arbiter.sv
// Arbitrates write chunks and read requests onto one TLP request channel.
// Grants are gated by posted/non-posted credits and a pool of read tags.
module tlp_req_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int NUM_TAGS        = 16,
  parameter int P_CREDITS       = 8,
  parameter int NP_CREDITS      = 8,
  parameter int TAG_W           = $clog2(NUM_TAGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 w_addr,
  input  logic [7:0]                            w_length,
  input  logic [15:0]                           w_bdf,
  input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] w_data,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [ADDR_WIDTH-1:0]                 r_addr,
  input  logic [7:0]                            r_length,
  input  logic                                  r_valid,
  output logic                                  r_ready,
  output logic                                  tx_is_write,
  output logic [ADDR_WIDTH-1:0]                 tx_addr,
  output logic [7:0]                            tx_length,
  output logic [15:0]                           tx_bdf,
  output logic [7:0]                            tx_tag,
  output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  input  logic                                  p_credit_ret,
  input  logic                                  np_credit_ret,
  input  logic                                  tag_rel_valid,
  input  logic [TAG_W-1:0]                      tag_rel_tag,
  output logic [TAG_W:0]                        tags_busy
);

  localparam int PW = DATA_WIDTH * CHUNK_MAX_BEATS;
  localparam logic [15:0] READ_BDF = 16'h0200;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic [7:0]             p_cnt_q, p_cnt_d;
  logic [7:0]             np_cnt_q, np_cnt_d;
  logic [NUM_TAGS-1:0]    busy_q, busy_d;
  logic [TAG_W:0]         tags_busy_q, tags_busy_d;

  logic                   tx_is_write_q, tx_is_write_d;
  logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
  logic [7:0]             tx_length_q, tx_length_d;
  logic [15:0]            tx_bdf_q, tx_bdf_d;
  logic [7:0]             tx_tag_q, tx_tag_d;
  logic [PW-1:0]          tx_data_q, tx_data_d;

  logic [TAG_W-1:0]       free_tag;
  logic                   any_free;
  logic                   wr_elig, rd_elig;
  logic                   wr_grant, rd_grant;
  logic [8:0]             p_sum, np_sum;

  // Lowest-index free tag; a tag released this cycle is still busy here.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_tag = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // Ties go to whichever source did not win last; rst_n keeps readies low in reset.
  always_comb begin
    wr_elig  = rst_n && (state_q == IDLE) && w_valid && (p_cnt_q != 8'd0);
    rd_elig  = rst_n && (state_q == IDLE) && r_valid && (np_cnt_q != 8'd0) && any_free;
    wr_grant = wr_elig && (!rd_elig || !last_wr_q);
    rd_grant = rd_elig && (!wr_elig || last_wr_q);
  end

  assign w_ready = wr_grant;
  assign r_ready = rd_grant;

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    busy_d        = busy_q;
    tags_busy_d   = '0;
    tx_is_write_d = tx_is_write_q;
    tx_addr_d     = tx_addr_q;
    tx_length_d   = tx_length_q;
    tx_bdf_d      = tx_bdf_q;
    tx_tag_d      = tx_tag_q;
    tx_data_d     = tx_data_q;

    case (state_q)
      IDLE: begin
        if (wr_grant) begin
          state_d       = HOLD;
          last_wr_d     = 1'b1;
          tx_is_write_d = 1'b1;
          tx_addr_d     = w_addr;
          tx_length_d   = w_length;
          tx_bdf_d      = w_bdf;
          tx_tag_d      = 8'd0;
          tx_data_d     = w_data;
        end else if (rd_grant) begin
          state_d       = HOLD;
          last_wr_d     = 1'b0;
          tx_is_write_d = 1'b0;
          tx_addr_d     = r_addr;
          tx_length_d   = r_length;
          tx_bdf_d      = READ_BDF;
          tx_tag_d      = 8'(free_tag);
          tx_data_d     = '0;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Releasing an idle tag is harmless: clearing a zero bit changes nothing.
    if (tag_rel_valid) begin
      busy_d[tag_rel_tag] = 1'b0;
    end
    if (rd_grant) begin
      busy_d[free_tag] = 1'b1;
    end

    for (int i = 0; i < NUM_TAGS; i++) begin
      tags_busy_d = tags_busy_d + (TAG_W+1)'(busy_d[i]);
    end
  end

  // A grant only happens with a nonzero count, so the sum never underflows.
  always_comb begin
    p_sum    = {1'b0, p_cnt_q} - {8'd0, wr_grant} + {8'd0, p_credit_ret};
    np_sum   = {1'b0, np_cnt_q} - {8'd0, rd_grant} + {8'd0, np_credit_ret};
    p_cnt_d  = p_sum[8] ? 8'hFF : p_sum[7:0];
    np_cnt_d = np_sum[8] ? 8'hFF : np_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_wr_q     <= 1'b0;
      p_cnt_q       <= 8'(P_CREDITS);
      np_cnt_q      <= 8'(NP_CREDITS);
      busy_q        <= '0;
      tags_busy_q   <= '0;
      tx_is_write_q <= 1'b0;
      tx_addr_q     <= '0;
      tx_length_q   <= '0;
      tx_bdf_q      <= '0;
      tx_tag_q      <= '0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_wr_q     <= last_wr_d;
      p_cnt_q       <= p_cnt_d;
      np_cnt_q      <= np_cnt_d;
      busy_q        <= busy_d;
      tags_busy_q   <= tags_busy_d;
      tx_is_write_q <= tx_is_write_d;
      tx_addr_q     <= tx_addr_d;
      tx_length_q   <= tx_length_d;
      tx_bdf_q      <= tx_bdf_d;
      tx_tag_q      <= tx_tag_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign tx_valid    = (state_q == HOLD);
  assign tx_is_write = tx_is_write_q;
  assign tx_addr     = tx_addr_q;
  assign tx_length   = tx_length_q;
  assign tx_bdf      = tx_bdf_q;
  assign tx_tag      = tx_tag_q;
  assign tx_data     = tx_data_q;
  assign tags_busy   = tags_busy_q;

endmodule

// File: tb/tb_tlp_req_arbiter.sv
// Directed bench for tlp_req_arbiter with a reference model and expected-request queue.
module tb_tlp_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CB = 4;
  localparam int PW = DW * CB;
  localparam int NT = 16;
  localparam int TW = 4;
  localparam int PC = 2;
  localparam int NPC = 32;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [15:0]   bdf;
    logic [7:0]    tag;
    logic [PW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [7:0] w_length = '0;
  logic [15:0] w_bdf = '0;
  logic [PW-1:0] w_data = '0;
  logic w_valid = 1'b0;
  logic w_ready;
  logic [AW-1:0] r_addr = '0;
  logic [7:0] r_length = '0;
  logic r_valid = 1'b0;
  logic r_ready;
  logic tx_is_write;
  logic [AW-1:0] tx_addr;
  logic [7:0] tx_length;
  logic [15:0] tx_bdf;
  logic [7:0] tx_tag;
  logic [PW-1:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic p_credit_ret = 1'b0;
  logic np_credit_ret = 1'b0;
  logic tag_rel_valid = 1'b0;
  logic [TW-1:0] tag_rel_tag = '0;
  logic [TW:0] tags_busy;

  int tests = 0;
  int fails = 0;
  int w_grants = 0;

  txn_t exp_q[$];
  logic hs_wr[$];
  logic [7:0] hs_tag[$];

  int p_m, np_m;
  logic [NT-1:0] busy_m;
  logic last_w_m, hold_m;

  tlp_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNK_MAX_BEATS(CB),
    .NUM_TAGS(NT), .P_CREDITS(PC), .NP_CREDITS(NPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_addr(w_addr), .w_length(w_length), .w_bdf(w_bdf), .w_data(w_data),
    .w_valid(w_valid), .w_ready(w_ready),
    .r_addr(r_addr), .r_length(r_length), .r_valid(r_valid), .r_ready(r_ready),
    .tx_is_write(tx_is_write), .tx_addr(tx_addr), .tx_length(tx_length),
    .tx_bdf(tx_bdf), .tx_tag(tx_tag), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .p_credit_ret(p_credit_ret), .np_credit_ret(np_credit_ret),
    .tag_rel_valid(tag_rel_valid), .tag_rel_tag(tag_rel_tag),
    .tags_busy(tags_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    w_addr   = $urandom;
    w_length = 8'($urandom_range(1, 4));
    w_bdf    = 16'($urandom);
    w_data   = {$urandom, $urandom, $urandom, $urandom};
    r_addr   = $urandom;
    r_length = 8'($urandom_range(1, 16));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    w_valid = 1'b0; r_valid = 1'b0; tx_ready = 1'b0;
    p_credit_ret = 1'b0; np_credit_ret = 1'b0; tag_rel_valid = 1'b0;
    hs_wr.delete();
    hs_tag.delete();
    w_grants = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference model, evaluated mid-cycle once inputs and registered outputs are settled.
  always @(negedge clk) begin
    logic [3:0] m_tag;
    logic m_free, w_el, r_el, e_w, e_r;
    logic [NT-1:0] nb;
    txn_t t, o;
    if (!rst_n) begin
      p_m = PC; np_m = NPC; busy_m = '0; last_w_m = 1'b0; hold_m = 1'b0;
      exp_q.delete();
    end else begin
      m_tag = '0; m_free = 1'b0;
      for (int i = NT - 1; i >= 0; i--)
        if (!busy_m[i]) begin m_tag = 4'(i); m_free = 1'b1; end
      w_el = !hold_m && w_valid && (p_m > 0);
      r_el = !hold_m && r_valid && (np_m > 0) && m_free;
      e_w  = w_el && (!r_el || !last_w_m);
      e_r  = r_el && (!w_el || last_w_m);
      checkOutput("w_ready", w_ready, e_w);
      checkOutput("r_ready", r_ready, e_r);
      checkOutput("tx_valid", tx_valid, hold_m);
      checkOutput("tags_busy", tags_busy, $countones(busy_m));
      if (w_ready) w_grants++;

      if (hold_m) begin
        o = '{tx_is_write, tx_addr, tx_length, tx_bdf, tx_tag, tx_data};
        if (exp_q.size() == 0) checkOutput("queue_empty", 1, 0);
        else checkOutput("tx_fields", o, exp_q[0]);
        if (tx_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_wr.push_back(tx_is_write);
          hs_tag.push_back(tx_tag);
        end
      end

      nb = busy_m;
      if (tag_rel_valid) nb[tag_rel_tag] = 1'b0;
      if (e_w) begin
        t = '{1'b1, w_addr, w_length, w_bdf, 8'd0, w_data};
        exp_q.push_back(t);
        last_w_m = 1'b1;
      end else if (e_r) begin
        t = '{1'b0, r_addr, r_length, 16'h0200, 8'(m_tag), '0};
        exp_q.push_back(t);
        nb[m_tag] = 1'b1;
        last_w_m = 1'b0;
      end
      busy_m = nb;
      p_m  = p_m - int'(e_w) + int'(p_credit_ret);
      np_m = np_m - int'(e_r) + int'(np_credit_ret);
      if (p_m > 255) p_m = 255;
      if (np_m > 255) np_m = 255;
      if (hold_m && tx_ready) hold_m = 1'b0;
      else if (e_w || e_r) hold_m = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values, with requests pending to show the readies stay low.
    w_valid = 1'b1; r_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_w_ready", w_ready, 0);
    checkOutput("rst_r_ready", r_ready, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tags_busy", tags_busy, 0);
    checkOutput("rst_tx_addr", tx_addr, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    doReset();

    // Alternation when both sources are always eligible.
    w_valid = 1'b1; r_valid = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      tick();
      if (hs_wr.size() >= 4) break;
    end
    w_valid = 1'b0; r_valid = 1'b0;
    checkOutput("alt_count", hs_wr.size(), 4);
    if (hs_wr.size() >= 4) begin
      checkOutput("alt_0", hs_wr[0], 1);
      checkOutput("alt_1", hs_wr[1], 0);
      checkOutput("alt_2", hs_wr[2], 1);
      checkOutput("alt_3", hs_wr[3], 0);
    end
    repeat (3) tick();

    // Exhaust the tag pool, then reuse a released tag.
    doReset();
    r_valid = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus();
      tick();
      if (hs_tag.size() >= 16) break;
    end
    checkOutput("tag_count", hs_tag.size(), 16);
    for (int i = 0; i < 16; i++)
      checkOutput("tag_order", hs_tag.size() > i ? hs_tag[i] : 8'hFF, i);
    repeat (3) begin
      @(negedge clk);
      checkOutput("tag_stall", r_ready, 0);
      tick();
    end
    @(negedge clk);
    checkOutput("tags_full", tags_busy, 16);
    tick();
    tag_rel_valid = 1'b1; tag_rel_tag = 4'd5;
    @(negedge clk);
    checkOutput("rel_same_cycle", r_ready, 0);
    tick();
    tag_rel_valid = 1'b0;
    @(negedge clk);
    checkOutput("rel_next_cycle", r_ready, 1);
    tick();
    r_valid = 1'b0;
    tick();
    checkOutput("tag_reuse", hs_tag.size() > 16 ? hs_tag[16] : 8'hFF, 5);

    // Posted credit exhaustion and return.
    doReset();
    w_valid = 1'b1; tx_ready = 1'b1;
    repeat (8) begin applyStimulus(); tick(); end
    checkOutput("p_grants", w_grants, PC);
    @(negedge clk);
    checkOutput("p_stall", w_ready, 0);
    tick();
    p_credit_ret = 1'b1;
    @(negedge clk);
    checkOutput("p_ret_cycle", w_ready, 0);
    tick();
    p_credit_ret = 1'b0;
    @(negedge clk);
    checkOutput("p_ret_grant", w_ready, 1);
    tick();
    w_valid = 1'b0;
    repeat (2) tick();

    // Back-pressure holds the request stable.
    doReset();
    tx_ready = 1'b0;
    applyStimulus();
    w_addr = 32'h1000; w_length = 8'd4; w_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_grant", w_ready, 1);
    tick();
    w_valid = 1'b0;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", tx_valid, 1);
      checkOutput("bp_addr", tx_addr, 32'h1000);
      checkOutput("bp_len", tx_length, 4);
      tick();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_hs_valid", tx_valid, 1);
    tick();
    @(negedge clk);
    checkOutput("bp_idle", tx_valid, 0);
    tick();

    // Drain non-posted credits to one, then grant with a simultaneous return.
    doReset();
    tx_ready = 1'b1;
    for (int i = 0; i < NPC - 1; i++) begin
      applyStimulus();
      r_valid = 1'b1;
      tick();
      r_valid = 1'b0; tag_rel_valid = 1'b1; tag_rel_tag = 4'd0;
      tick();
      tag_rel_valid = 1'b0;
    end
    r_valid = 1'b1; np_credit_ret = 1'b1;
    @(negedge clk);
    checkOutput("np_last_grant", r_ready, 1);
    tick();
    r_valid = 1'b0; np_credit_ret = 1'b0;
    tick();
    r_valid = 1'b1;
    @(negedge clk);
    checkOutput("np_kept_one", r_ready, 1);
    tick();
    r_valid = 1'b0;
    tick();
    r_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("np_empty", r_ready, 0);
      tick();
    end
    r_valid = 1'b0;
    @(negedge clk);
    checkOutput("np_tags_busy", tags_busy, 2);
    tick();
    tag_rel_valid = 1'b1; tag_rel_tag = 4'd9;
    tick();
    tag_rel_valid = 1'b0;
    @(negedge clk);
    checkOutput("rel_idle_tag", tags_busy, 2);
    tick();

    // Reset in the middle of a held request.
    doReset();
    applyStimulus();
    w_valid = 1'b1; tx_ready = 1'b0;
    tick();
    w_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    w_valid = 1'b1; r_valid = 1'b1;
    #1;
    checkOutput("async_tx_valid", tx_valid, 0);
    checkOutput("async_w_ready", w_ready, 0);
    checkOutput("async_r_ready", r_ready, 0);
    checkOutput("async_tx_addr", tx_addr, 0);
    w_valid = 1'b0; r_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    w_grants = 0;
    @(negedge clk);
    checkOutput("post_rst_tags", tags_busy, 0);
    tick();
    w_valid = 1'b1; tx_ready = 1'b1;
    repeat (8) begin applyStimulus(); tick(); end
    w_valid = 1'b0;
    checkOutput("post_rst_credits", w_grants, PC);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
